dl_monitor_unit: RTL and testbench



---
 rtl/dl_monitor_unit.sv | 208 ++++++++++++++++++++
 tb/tb_dl_monitor_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dl_monitor_unit.sv
// Dataflow deadlock monitor: watches the process wait-for graph, declares a
// deadlock after a stable stall, then walks the frozen graph and streams out
// every wait circle one process per handshake beat.
module dl_monitor_unit #(
    parameter int PROC_NUM     = 4,
    parameter int STALL_CYCLES = 16,
    localparam int IDX_W       = (PROC_NUM > 2) ? $clog2(PROC_NUM) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [PROC_NUM*PROC_NUM-1:0] wait_vec,
    output logic                         dl_detect_out,
    output logic [PROC_NUM-1:0]          origin,
    output logic                         rpt_valid,
    input  logic                         rpt_ready,
    output logic [IDX_W-1:0]             rpt_proc,
    output logic [7:0]                   rpt_circle,
    output logic                         rpt_last,
    output logic                         token_clear,
    output logic                         rpt_done,
    output logic [7:0]                   rpt_count
);

    typedef enum logic [2:0] {
        IDLE, ARMED, SELECT, WALK, REPORT, FINISH
    } state_t;

    localparam logic [15:0]    STALL_MAX = 16'(STALL_CYCLES);
    localparam logic [IDX_W:0] STEP_MAX  = (IDX_W+1)'(PROC_NUM);

    state_t                         state_q, state_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic [PROC_NUM*PROC_NUM-1:0]   prev_q, prev_d;
    logic [PROC_NUM*PROC_NUM-1:0]   snap_q, snap_d;
    logic [PROC_NUM-1:0]            done_q, done_d;
    logic [PROC_NUM-1:0]            visited_q, visited_d;
    logic [PROC_NUM-1:0]            origin_q, origin_d;
    logic [IDX_W-1:0]               cur_q, cur_d;
    logic [IDX_W-1:0]               head_q, head_d;
    logic [IDX_W:0]                 step_q, step_d;
    logic [7:0]                     circle_q, circle_d;
    logic [7:0]                     count_q, count_d;
    logic                           detect_q, detect_d;

    // Frozen graph split into per-process rows (row i = processes i waits on)
    logic [PROC_NUM-1:0] snap_rows [PROC_NUM];
    logic [PROC_NUM-1:0] row_nz;

    generate
        for (genvar gi = 0; gi < PROC_NUM; gi++) begin : g_rows
            assign snap_rows[gi] = snap_q[gi*PROC_NUM +: PROC_NUM];
            assign row_nz[gi]    = |snap_rows[gi];
        end
    endgenerate

    // Index of the lowest set bit; every hop follows the lowest-index edge
    function automatic logic [IDX_W-1:0] lowest(input logic [PROC_NUM-1:0] v);
        lowest = '0;
        for (int k = PROC_NUM - 1; k >= 0; k--) begin
            if (v[k]) lowest = IDX_W'(k);
        end
    endfunction

    logic [IDX_W-1:0]    nxt;
    logic [PROC_NUM-1:0] cur_oh, nxt_oh, vis_now, cand;
    logic                beat_last, accept;

    assign nxt       = lowest(snap_rows[cur_q]);
    assign cur_oh    = PROC_NUM'(1) << cur_q;
    assign nxt_oh    = PROC_NUM'(1) << nxt;
    assign vis_now   = visited_q | cur_oh;
    assign cand      = row_nz & ~done_q;
    assign beat_last = (state_q == REPORT) && (nxt == head_q);
    assign accept    = (state_q == REPORT) && rpt_ready;

    assign dl_detect_out = detect_q;
    assign origin        = origin_q;
    assign rpt_valid     = (state_q == REPORT);
    assign rpt_proc      = rpt_valid ? cur_q : '0;
    assign rpt_circle    = rpt_valid ? circle_q : 8'd0;
    assign rpt_last      = beat_last;
    assign token_clear   = accept && beat_last;
    assign rpt_done      = (state_q == FINISH);
    assign rpt_count     = count_q;

    // State and datapath registers; reset returns everything to a clean idle
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= '0;
            snap_q    <= '0;
            done_q    <= '0;
            visited_q <= '0;
            origin_q  <= '0;
            cur_q     <= '0;
            head_q    <= '0;
            step_q    <= '0;
            circle_q  <= 8'd1;
            count_q   <= '0;
            detect_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            snap_q    <= snap_d;
            done_q    <= done_d;
            visited_q <= visited_d;
            origin_q  <= origin_d;
            cur_q     <= cur_d;
            head_q    <= head_d;
            step_q    <= step_d;
            circle_q  <= circle_d;
            count_q   <= count_d;
            detect_q  <= detect_d;
        end
    end

    // Next-state logic: stall detection, graph walk, circle reporting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        snap_d    = snap_q;
        done_d    = done_q;
        visited_d = visited_q;
        origin_d  = origin_q;
        cur_d     = cur_q;
        head_d    = head_q;
        step_d    = step_q;
        circle_d  = circle_q;
        count_d   = count_q;
        detect_d  = detect_q;

        unique case (state_q)
            IDLE: begin
                if (enable && (wait_vec != '0)) begin
                    state_d = ARMED;
                    cnt_d   = 16'd1;
                    prev_d  = wait_vec;
                end
            end
            ARMED: begin
                if (!enable || (wait_vec == '0)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= STALL_MAX) begin
                    // Pattern has been stable long enough: freeze it
                    state_d  = SELECT;
                    snap_d   = prev_q;
                    detect_d = 1'b1;
                end else if (wait_vec == prev_q) begin
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                end else begin
                    cnt_d  = 16'd1;
                    prev_d = wait_vec;
                end
            end
            SELECT: begin
                if (cand == '0) begin
                    state_d = FINISH;
                end else begin
                    state_d   = WALK;
                    cur_d     = lowest(cand);
                    visited_d = '0;
                    step_d    = '0;
                end
            end
            WALK: begin
                // A hop into a dead end or an already-handled process closes
                // this chain without a circle; tails are never reported.
                if (!row_nz[nxt] || done_q[nxt] || (step_q >= STEP_MAX)) begin
                    state_d = SELECT;
                    done_d  = done_q | vis_now | nxt_oh;
                end else if (vis_now[nxt]) begin
                    state_d   = REPORT;
                    head_d    = nxt;
                    cur_d     = nxt;
                    origin_d  = nxt_oh;
                    visited_d = vis_now;
                end else begin
                    cur_d     = nxt;
                    visited_d = vis_now;
                    step_d    = step_q + 1'b1;
                end
            end
            REPORT: begin
                if (accept) begin
                    if (beat_last) begin
                        state_d  = SELECT;
                        done_d   = done_q | visited_q;
                        origin_d = '0;
                        circle_d = (circle_q == 8'hFF) ? circle_q : circle_q + 8'd1;
                        count_d  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    end else begin
                        cur_d = nxt;
                    end
                end
            end
            FINISH: begin
                state_d = FINISH;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dl_monitor_unit.sv
// Directed bench for dl_monitor_unit (PROC_NUM=4, STALL_CYCLES=8): a table of
// whole-graph scenarios plus hand sequences for stall restart, enable drop,
// back-pressure and reset during a report beat.
module tb_dl_monitor_unit;

    localparam int PN = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [15:0]   wait_vec;
    logic          dl_detect_out;
    logic [PN-1:0] origin;
    logic          rpt_valid;
    logic          rpt_ready;
    logic [1:0]    rpt_proc;
    logic [7:0]    rpt_circle;
    logic          rpt_last;
    logic          token_clear;
    logic          rpt_done;
    logic [7:0]    rpt_count;

    dl_monitor_unit #(.PROC_NUM(PN), .STALL_CYCLES(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .wait_vec      (wait_vec),
        .dl_detect_out (dl_detect_out),
        .origin        (origin),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rpt_ready),
        .rpt_proc      (rpt_proc),
        .rpt_circle    (rpt_circle),
        .rpt_last      (rpt_last),
        .token_clear   (token_clear),
        .rpt_done      (rpt_done),
        .rpt_count     (rpt_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] wv;
        int          nbeats;
        int          ncirc;
        int          procs [4];
        int          lasts [4];
        int          circs [4];
        int          origs [4];
    } vec_t;

    vec_t vecs [5];

    int nb, tc;
    int got_proc [8];
    int got_last [8];
    int got_circ [8];
    int got_orig [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; enable = 1'b0; wait_vec = '0; rpt_ready = 1'b1;
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drives the graph now (cycle 0) and counts edges until the detect flag
    task automatic run_detect(input logic [15:0] wv, output int det);
        enable = 1'b1; wait_vec = wv; det = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); @(negedge clock);
            if (dl_detect_out) begin det = k; break; end
        end
    endtask

    // Records accepted beats and token pulses until rpt_done (bounded)
    task automatic collect(input int maxc);
        nb = 0; tc = 0;
        for (int c = 0; c < maxc; c++) begin
            if (rpt_valid && rpt_ready) begin
                if (nb < 8) begin
                    got_proc[nb] = int'(rpt_proc);
                    got_last[nb] = int'(rpt_last);
                    got_circ[nb] = int'(rpt_circle);
                    got_orig[nb] = int'(origin);
                end
                nb++;
            end
            if (token_clear) tc++;
            if (rpt_done) break;
            @(posedge clock); @(negedge clock);
        end
    endtask

    int det;

    initial begin
        reset = 1'b1; enable = 1'b0; wait_vec = '0; rpt_ready = 1'b1;

        // edges 0->1,1->0
        vecs[0].wv = 16'h0012; vecs[0].nbeats = 2; vecs[0].ncirc = 1;
        vecs[0].procs = '{0, 1, 0, 0}; vecs[0].lasts = '{0, 1, 0, 0};
        vecs[0].circs = '{1, 1, 0, 0}; vecs[0].origs = '{1, 1, 0, 0};
        // two disjoint circles 0<->1, 2<->3
        vecs[1].wv = 16'h4812; vecs[1].nbeats = 4; vecs[1].ncirc = 2;
        vecs[1].procs = '{0, 1, 2, 3}; vecs[1].lasts = '{0, 1, 0, 1};
        vecs[1].circs = '{1, 1, 2, 2}; vecs[1].origs = '{1, 1, 4, 4};
        // tail 0 into circle 1<->2
        vecs[2].wv = 16'h0242; vecs[2].nbeats = 2; vecs[2].ncirc = 1;
        vecs[2].procs = '{1, 2, 0, 0}; vecs[2].lasts = '{0, 1, 0, 0};
        vecs[2].circs = '{1, 1, 0, 0}; vecs[2].origs = '{2, 2, 0, 0};
        // self-loop on process 2
        vecs[3].wv = 16'h0400; vecs[3].nbeats = 1; vecs[3].ncirc = 1;
        vecs[3].procs = '{2, 0, 0, 0}; vecs[3].lasts = '{1, 0, 0, 0};
        vecs[3].circs = '{1, 0, 0, 0}; vecs[3].origs = '{4, 0, 0, 0};
        // circle 0<->1 plus process 2 waiting into it: reported once only
        vecs[4].wv = 16'h0112; vecs[4].nbeats = 2; vecs[4].ncirc = 1;
        vecs[4].procs = '{0, 1, 0, 0}; vecs[4].lasts = '{0, 1, 0, 0};
        vecs[4].circs = '{1, 1, 0, 0}; vecs[4].origs = '{1, 1, 0, 0};

        // Reset state
        do_reset();
        chk("rst_detect", 32'(dl_detect_out), 0);
        chk("rst_valid",  32'(rpt_valid), 0);
        chk("rst_done",   32'(rpt_done), 0);
        chk("rst_count",  32'(rpt_count), 0);
        chk("rst_origin", 32'(origin), 0);
        chk("rst_circle", 32'(rpt_circle), 0);
        $display("reset state checked");

        // Table-driven scenarios
        for (int s = 0; s < 5; s++) begin
            do_reset();
            run_detect(vecs[s].wv, det);
            chk("detect_cycle", 32'(det), 9);
            collect(80);
            chk("beat_count", 32'(nb), 32'(vecs[s].nbeats));
            chk("token_pulses", 32'(tc), 32'(vecs[s].ncirc));
            chk("rpt_count", 32'(rpt_count), 32'(vecs[s].ncirc));
            chk("rpt_done", 32'(rpt_done), 1);
            chk("valid_at_done", 32'(rpt_valid), 0);
            for (int b = 0; b < vecs[s].nbeats && b < nb && b < 4; b++) begin
                chk("beat_proc",   32'(got_proc[b]), 32'(vecs[s].procs[b]));
                chk("beat_last",   32'(got_last[b]), 32'(vecs[s].lasts[b]));
                chk("beat_circle", 32'(got_circ[b]), 32'(vecs[s].circs[b]));
                chk("beat_origin", 32'(got_orig[b]), 32'(vecs[s].origs[b]));
            end
            $display("scenario %0d wv=%h det=%0d beats=%0d count=%0d", s, vecs[s].wv, det, nb, rpt_count);
        end

        // Graph changes at cycle 5: stall counter restarts, chain 0->1->2 ends
        do_reset();
        enable = 1'b1; wait_vec = 16'h0012; det = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); @(negedge clock);
            if (dl_detect_out) begin det = k; break; end
            if (k == 5) wait_vec = 16'h0042;
        end
        chk("restart_detect_cycle", 32'(det), 14);
        collect(80);
        chk("chain_beats", 32'(nb), 0);
        chk("chain_count", 32'(rpt_count), 0);
        chk("chain_done", 32'(rpt_done), 1);
        $display("chain scenario det=%0d beats=%0d", det, nb);

        // Enable dropped for one cycle: back to idle, counter starts over
        do_reset();
        enable = 1'b1; wait_vec = 16'h0012; det = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); @(negedge clock);
            if (dl_detect_out) begin det = k; break; end
            enable = (k == 5) ? 1'b0 : 1'b1;
        end
        chk("enable_drop_detect_cycle", 32'(det), 15);
        $display("enable drop scenario det=%0d", det);

        // Back-pressure on the first beat
        do_reset();
        rpt_ready = 1'b0;
        run_detect(16'h0012, det);
        chk("bp_detect_cycle", 32'(det), 9);
        for (int k = 0; k < 20 && !rpt_valid; k++) begin
            @(posedge clock); @(negedge clock);
        end
        for (int h = 0; h < 3; h++) begin
            chk("bp_valid_held", 32'(rpt_valid), 1);
            chk("bp_proc_held",  32'(rpt_proc), 0);
            chk("bp_last_held",  32'(rpt_last), 0);
            chk("bp_no_token",   32'(token_clear), 0);
            if (h < 2) begin @(posedge clock); @(negedge clock); end
        end
        rpt_ready = 1'b1;
        collect(80);
        chk("bp_beats", 32'(nb), 2);
        chk("bp_proc0", 32'(got_proc[0]), 0);
        chk("bp_proc1", 32'(got_proc[1]), 1);
        chk("bp_last1", 32'(got_last[1]), 1);
        chk("bp_tokens", 32'(tc), 1);
        chk("bp_count", 32'(rpt_count), 1);
        $display("backpressure scenario beats=%0d count=%0d", nb, rpt_count);

        // Reset during the first report beat, then detection repeats
        do_reset();
        run_detect(16'h0012, det);
        for (int k = 0; k < 20 && !rpt_valid; k++) begin
            @(posedge clock); @(negedge clock);
        end
        chk("mid_valid_before_reset", 32'(rpt_valid), 1);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("mid_rst_valid",  32'(rpt_valid), 0);
        chk("mid_rst_detect", 32'(dl_detect_out), 0);
        chk("mid_rst_origin", 32'(origin), 0);
        chk("mid_rst_token",  32'(token_clear), 0);
        chk("mid_rst_count",  32'(rpt_count), 0);
        chk("mid_rst_done",   32'(rpt_done), 0);
        reset = 1'b0;
        run_detect(16'h0012, det);
        chk("redetect_cycle", 32'(det), 9);
        $display("reset-during-report scenario redetect=%0d", det);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
